// File: rtl/ifetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl_pkg
// Description : Shared types and constants for the instruction-fetch
//               controller: common scalar types, FSM state encoding, ibus
//               request/response records, fetch output record and the
//               control strobes passed from the FSM to the datapath.
// Options     : IFETCH_MISALIGN_CHK_EN adds the misalign flag to the fetch
//               output record.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_ctrl_pkg;

  // Common scalar types
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic        u1;

  // RISC-V "addi x0, x0, 0", presented to decode for a misaligned PC
  localparam u32 NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } ifetch_state_t;

  typedef struct packed {
    u1  valid;
    u64 addr;
  } ibus_req_t;

  typedef struct packed {
    u1  addr_ok;
    u1  data_ok;
    u32 data;
  } ibus_resp_t;

  typedef struct packed {
    u1  valid;
    u64 pc;
    u32 instr;
`ifdef IFETCH_MISALIGN_CHK_EN
    u1  misalign;
`endif
  } fetch_data_t;

  // One-cycle strobes from the FSM to the datapath registers
  typedef struct packed {
    u1 latch_pc;  // sample pc into the request address register
    u1 capture;   // load bus data and request PC into the output registers
    u1 load_nop;  // load NOP and the current pc (misaligned fetch)
    u1 handoff;   // decode accepts the held instruction this cycle
  } fetch_ctrl_t;

  // True when the two low PC bits indicate a non-word-aligned address
  function automatic u1 pc_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction

endpackage : ifetch_ctrl_pkg
`default_nettype wire

// File: rtl/ifetch_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fsm
// Description : Control FSM of the instruction-fetch controller. Sequences
//               IDLE -> REQ -> (WAIT) -> HOLD -> IDLE, with DROP used to
//               absorb a bus response belonging to a flushed fetch. Owns
//               the registered control outputs (ireq_valid, out_valid and
//               optionally misalign) and emits datapath strobes.
// Ports       : clk, reset         - clock, async active-high reset
//               misalign_i         - current pc is misaligned (option only)
//               addr_ok_i/data_ok_i- ibus handshake
//               dec_ready_i        - decode accepts
//               flush_i            - redirect / discard
//               ireq_valid_o       - registered bus request valid
//               out_valid_o        - registered instruction valid
//               misalign_o         - registered misalign flag (option only)
//               ctrl_o             - datapath strobes
// Options     : IFETCH_MISALIGN_CHK_EN enables the misaligned-PC bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fsm
  import ifetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef IFETCH_MISALIGN_CHK_EN
  input  logic        misalign_i,
  output logic        misalign_o,
`endif
  input  logic        addr_ok_i,
  input  logic        data_ok_i,
  input  logic        dec_ready_i,
  input  logic        flush_i,
  output logic        ireq_valid_o,
  output logic        out_valid_o,
  output fetch_ctrl_t ctrl_o
);

  ifetch_state_t state_q;
  logic          flush_pend_q;
  logic          ireq_valid_q;
  logic          out_valid_q;
  logic          w_flush_req;
  logic          w_misalign;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic          misalign_q;
  assign w_misalign = misalign_i;
  assign misalign_o = misalign_q;
`else
  assign w_misalign = 1'b0;
`endif

  // A flush seen at any point while the request is outstanding condemns it;
  // the request itself must stay up until the bus takes the address.
  assign w_flush_req = flush_pend_q | flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      flush_pend_q <= 1'b0;
      ireq_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          flush_pend_q <= 1'b0;
          if (w_misalign) begin
            // No bus traffic: present a NOP tagged as misaligned
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_q  <= 1'b1;
`endif
          end else begin
            state_q      <= S_REQ;
            ireq_valid_q <= 1'b1;
          end
        end

        S_REQ: begin
          if (addr_ok_i) begin
            ireq_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            if (w_flush_req) begin
              // Same-cycle data of a flushed fetch is simply discarded
              state_q <= data_ok_i ? S_IDLE : S_DROP;
            end else if (data_ok_i) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            flush_pend_q <= w_flush_req;
          end
        end

        S_WAIT: begin
          if (flush_i) begin
            // Data arriving with the flush needs no DROP phase
            state_q <= data_ok_i ? S_IDLE : S_DROP;
          end else if (data_ok_i) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
          end
        end

        S_HOLD: begin
          // Flush and acceptance both retire the held instruction
          if (flush_i || dec_ready_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
          end
        end

        S_DROP: begin
          if (data_ok_i) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          flush_pend_q <= 1'b0;
          ireq_valid_q <= 1'b0;
          out_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ireq_valid_o = ireq_valid_q;
  assign out_valid_o  = out_valid_q;

  always_comb begin
    ctrl_o          = '0;
    ctrl_o.latch_pc = (state_q == S_IDLE);
    ctrl_o.capture  = ((state_q == S_REQ)  & addr_ok_i & data_ok_i & ~w_flush_req) |
                      ((state_q == S_WAIT) & data_ok_i & ~flush_i);
    ctrl_o.load_nop = (state_q == S_IDLE) & w_misalign;
    ctrl_o.handoff  = (state_q == S_HOLD) & out_valid_q & dec_ready_i & ~flush_i;
  end

endmodule : ifetch_fsm
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl
// Description : Instruction-fetch controller between the PC register, the
//               instruction bus and decode. Requests the instruction at the
//               current PC, holds the result for decode with valid/ready and
//               stalls the PC register except in the cycle decode accepts.
// Ports       : clk, reset                   - clock, async active-high reset
//               pc                           - PC from the PC register
//               stall                        - hold PC register (0 = advance)
//               ireq_valid, ireq_addr        - ibus request
//               iresp_addr_ok/data_ok/data   - ibus response
//               out_valid, out_pc, out_instr - instruction to decode
//               out_misalign                 - misaligned-PC flag (option)
//               dec_ready                    - decode accepts
//               flush                        - discard in-flight/held fetch
// Options     : IFETCH_MISALIGN_CHK_EN adds out_misalign and replaces fetches
//               from misaligned PCs with a tagged NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               stall,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_addr_ok,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
`ifdef IFETCH_MISALIGN_CHK_EN
  output logic               out_misalign,
`endif
  input  logic               dec_ready,
  input  logic               flush
);

  localparam logic [INSTR_W-1:0] C_NOP = INSTR_W'(NOP_INSTR);

  fetch_ctrl_t        w_ctrl;
  logic [ADDR_W-1:0]  req_pc_q,    req_pc_d;
  logic [ADDR_W-1:0]  out_pc_q,    out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;

  ifetch_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
`ifdef IFETCH_MISALIGN_CHK_EN
    .misalign_i   (pc_misaligned(pc[1:0])),
    .misalign_o   (out_misalign),
`endif
    .addr_ok_i    (iresp_addr_ok),
    .data_ok_i    (iresp_data_ok),
    .dec_ready_i  (dec_ready),
    .flush_i      (flush),
    .ireq_valid_o (ireq_valid),
    .out_valid_o  (out_valid),
    .ctrl_o       (w_ctrl)
  );

  always_comb begin
    req_pc_d    = req_pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (w_ctrl.latch_pc) begin
      req_pc_d = pc;
    end
    if (w_ctrl.capture) begin
      out_pc_d    = req_pc_q;
      out_instr_d = iresp_data;
    end
    if (w_ctrl.load_nop) begin
      out_pc_d    = pc;
      out_instr_d = C_NOP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pc_q    <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      req_pc_q    <= req_pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  // The request address register only changes in IDLE, so it is stable for
  // the whole time ireq_valid is high.
  assign ireq_addr = req_pc_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

  // PC register advances only on the edge that ends an accepted handoff
  assign stall = reset | ~w_ctrl.handoff;

endmodule : ifetch_ctrl
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_ctrl
// Description : Self-checking bench for ifetch_ctrl. A cycle table drives
//               the bus/decode/flush inputs and lists the expected outputs
//               for each cycle; a small PC-register model advances pc by 4
//               whenever stall is low and can be loaded for redirects.
//               Hand-written sequences cover mid-transaction reset and the
//               misaligned-PC option (IFETCH_MISALIGN_CHK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

  localparam logic [63:0] A = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        stall;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        dec_ready;
  logic        flush;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        out_misalign;
`endif

  logic        pc_load;
  logic [63:0] pc_load_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // PC register model: load has priority, otherwise advance when not stalled
  always @(posedge clk) begin
    if (pc_load)     pc <= pc_load_val;
    else if (!stall) pc <= pc + 64'd4;
  end

  ifetch_ctrl #(.ADDR_W(64), .INSTR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .stall         (stall),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
`ifdef IFETCH_MISALIGN_CHK_EN
    .out_misalign  (out_misalign),
`endif
    .dec_ready     (dec_ready),
    .flush         (flush)
  );

  typedef struct {
    logic        aok;
    logic        dok;
    logic [31:0] data;
    logic        rdy;
    logic        fl;
    logic        ld;
    logic [63:0] ldv;
    logic        e_rv;
    logic [63:0] e_ra;
    logic        e_ov;
    logic [63:0] e_opc;
    logic [31:0] e_oi;
    logic        e_st;
  } vec_t;

  localparam int NV = 32;
  vec_t v[NV];

  function automatic vec_t mk(input logic aok, input logic dok, input logic [31:0] data,
                              input logic rdy, input logic fl, input logic ld,
                              input logic [63:0] ldv, input logic e_rv, input logic [63:0] e_ra,
                              input logic e_ov, input logic [63:0] e_opc,
                              input logic [31:0] e_oi, input logic e_st);
    vec_t r;
    r.aok = aok; r.dok = dok; r.data = data; r.rdy = rdy; r.fl = fl;
    r.ld = ld; r.ldv = ldv; r.e_rv = e_rv; r.e_ra = e_ra; r.e_ov = e_ov;
    r.e_opc = e_opc; r.e_oi = e_oi; r.e_st = e_st;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = 32'h0;
    flush         = 1'b0;
    pc_load       = 1'b0;
  endtask

  initial begin
    // Columns: aok dok data rdy fl ld ldv | ireq_valid ireq_addr out_valid out_pc out_instr stall
    // Zero-wait fetch and handoff
    v[0]  = mk(0,0,32'h0,        1,0,0,64'h0,     0,64'h0,   0,64'h0,   32'h0,        1);
    v[1]  = mk(1,1,32'h0000_0093,1,0,0,64'h0,     1,A,       0,64'h0,   32'h0,        1);
    v[2]  = mk(0,0,32'h0,        1,0,0,64'h0,     0,A,       1,A,       32'h0000_0093,0);
    v[3]  = mk(0,0,32'h0,        1,0,0,64'h0,     0,A,       0,A,       32'h0000_0093,1);
    // addr_ok after 3 cycles, data_ok 2 cycles later
    v[4]  = mk(0,0,32'h0,        1,0,0,64'h0,     1,A+4,     0,A,       32'h0000_0093,1);
    v[5]  = mk(0,0,32'h0,        1,0,0,64'h0,     1,A+4,     0,A,       32'h0000_0093,1);
    v[6]  = mk(0,0,32'h0,        1,0,0,64'h0,     1,A+4,     0,A,       32'h0000_0093,1);
    v[7]  = mk(1,0,32'h0,        1,0,0,64'h0,     1,A+4,     0,A,       32'h0000_0093,1);
    v[8]  = mk(0,0,32'h0,        1,0,0,64'h0,     0,A+4,     0,A,       32'h0000_0093,1);
    v[9]  = mk(0,1,32'h0010_0113,1,0,0,64'h0,     0,A+4,     0,A,       32'h0000_0093,1);
    // Decode back-pressure for 4 cycles, then one handoff
    v[10] = mk(0,0,32'h0,        0,0,0,64'h0,     0,A+4,     1,A+4,     32'h0010_0113,1);
    v[11] = mk(0,0,32'h0,        0,0,0,64'h0,     0,A+4,     1,A+4,     32'h0010_0113,1);
    v[12] = mk(0,0,32'h0,        0,0,0,64'h0,     0,A+4,     1,A+4,     32'h0010_0113,1);
    v[13] = mk(0,0,32'h0,        0,0,0,64'h0,     0,A+4,     1,A+4,     32'h0010_0113,1);
    v[14] = mk(0,0,32'h0,        1,0,0,64'h0,     0,A+4,     1,A+4,     32'h0010_0113,0);
    v[15] = mk(0,0,32'h0,        1,0,0,64'h0,     0,A+4,     0,A+4,     32'h0010_0113,1);
    // Flush in WAIT with redirect; late data 0xDEADBEEF is dropped
    v[16] = mk(1,0,32'h0,        1,0,0,64'h0,     1,A+8,     0,A+4,     32'h0010_0113,1);
    v[17] = mk(0,0,32'h0,        1,1,1,A+64'h100, 0,A+8,     0,A+4,     32'h0010_0113,1);
    v[18] = mk(0,1,32'hDEAD_BEEF,1,0,0,64'h0,     0,A+8,     0,A+4,     32'h0010_0113,1);
    v[19] = mk(0,0,32'h0,        1,0,0,64'h0,     0,A+8,     0,A+4,     32'h0010_0113,1);
    // Flush in HOLD with dec_ready: no handoff, no PC advance
    v[20] = mk(1,1,32'h0020_0193,1,0,0,64'h0,     1,A+64'h100,0,A+4,    32'h0010_0113,1);
    v[21] = mk(0,0,32'h0,        1,1,0,64'h0,     0,A+64'h100,1,A+64'h100,32'h0020_0193,1);
    v[22] = mk(0,0,32'h0,        1,0,0,64'h0,     0,A+64'h100,0,A+64'h100,32'h0020_0193,1);
    v[23] = mk(1,1,32'h0030_0213,1,0,0,64'h0,     1,A+64'h100,0,A+64'h100,32'h0020_0193,1);
    v[24] = mk(0,0,32'h0,        1,0,0,64'h0,     0,A+64'h100,1,A+64'h100,32'h0030_0213,0);
    v[25] = mk(0,0,32'h0,        1,0,0,64'h0,     0,A+64'h100,0,A+64'h100,32'h0030_0213,1);
    // Flush in REQ: request stays up until addr_ok, same-cycle data dropped
    v[26] = mk(0,0,32'h0,        1,1,0,64'h0,     1,A+64'h104,0,A+64'h100,32'h0030_0213,1);
    v[27] = mk(0,0,32'h0,        1,0,0,64'h0,     1,A+64'h104,0,A+64'h100,32'h0030_0213,1);
    v[28] = mk(1,1,32'h0000_0BAD,1,0,0,64'h0,     1,A+64'h104,0,A+64'h100,32'h0030_0213,1);
    v[29] = mk(0,0,32'h0,        1,0,0,64'h0,     0,A+64'h104,0,A+64'h100,32'h0030_0213,1);
    v[30] = mk(1,0,32'h0,        1,0,0,64'h0,     1,A+64'h104,0,A+64'h100,32'h0030_0213,1);
    v[31] = mk(0,0,32'h0,        1,0,0,64'h0,     0,A+64'h104,0,A+64'h100,32'h0030_0213,1);

    // Reset with the PC register loaded to the boot address
    reset       = 1'b1;
    dec_ready   = 1'b1;
    drive_idle();
    pc_load     = 1'b1;
    pc_load_val = A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset ireq_valid", {63'h0, ireq_valid}, 64'h0);
    chk("reset ireq_addr",  ireq_addr,           64'h0);
    chk("reset out_valid",  {63'h0, out_valid},  64'h0);
    chk("reset out_pc",     out_pc,              64'h0);
    chk("reset out_instr",  {32'h0, out_instr},  64'h0);
    chk("reset stall",      {63'h0, stall},      64'h1);
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("reset out_misalign", {63'h0, out_misalign}, 64'h0);
`endif
    reset   = 1'b0;
    pc_load = 1'b0;

    for (int i = 0; i < NV; i++) begin
      iresp_addr_ok = v[i].aok;
      iresp_data_ok = v[i].dok;
      iresp_data    = v[i].data;
      dec_ready     = v[i].rdy;
      flush         = v[i].fl;
      pc_load       = v[i].ld;
      pc_load_val   = v[i].ldv;
      #1;
      chk($sformatf("row%0d ireq_valid", i), {63'h0, ireq_valid}, {63'h0, v[i].e_rv});
      chk($sformatf("row%0d ireq_addr", i),  ireq_addr,           v[i].e_ra);
      chk($sformatf("row%0d out_valid", i),  {63'h0, out_valid},  {63'h0, v[i].e_ov});
      chk($sformatf("row%0d out_pc", i),     out_pc,              v[i].e_opc);
      chk($sformatf("row%0d out_instr", i),  {32'h0, out_instr},  {32'h0, v[i].e_oi});
      chk($sformatf("row%0d stall", i),      {63'h0, stall},      {63'h0, v[i].e_st});
      @(posedge clk);
      @(negedge clk);
    end

    // Asynchronous reset while waiting for data: immediate return to reset values
    drive_idle();
    #2 reset = 1'b1;
    #1;
    chk("midrst ireq_valid", {63'h0, ireq_valid}, 64'h0);
    chk("midrst ireq_addr",  ireq_addr,           64'h0);
    chk("midrst out_pc",     out_pc,              64'h0);
    chk("midrst out_instr",  {32'h0, out_instr},  64'h0);
    chk("midrst stall",      {63'h0, stall},      64'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postrst idle ireq_valid", {63'h0, ireq_valid}, 64'h0);
    @(negedge clk);
    #1;
    chk("postrst ireq_valid", {63'h0, ireq_valid}, 64'h1);
    chk("postrst ireq_addr",  ireq_addr,           A + 64'h104);

`ifdef IFETCH_MISALIGN_CHK_EN
    // Misaligned PC: NOP presented without any bus request
    reset       = 1'b1;
    pc_load     = 1'b1;
    pc_load_val = A + 64'h2;
    dec_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    pc_load = 1'b0;
    #1;
    chk("mis idle ireq_valid", {63'h0, ireq_valid}, 64'h0);
    @(negedge clk);
    #1;
    chk("mis ireq_valid",   {63'h0, ireq_valid},   64'h0);
    chk("mis out_valid",    {63'h0, out_valid},    64'h1);
    chk("mis out_instr",    {32'h0, out_instr},    64'h13);
    chk("mis out_pc",       out_pc,                A + 64'h2);
    chk("mis out_misalign", {63'h0, out_misalign}, 64'h1);
    chk("mis stall",        {63'h0, stall},        64'h0);
    @(negedge clk);
    #1;
    chk("mis clr out_valid",    {63'h0, out_valid},    64'h0);
    chk("mis clr out_misalign", {63'h0, out_misalign}, 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ifetch_ctrl
`default_nettype wire
